csa_multicycle_add_ctrl: RTL and testbench

//  Sequencer/arbiter sharing one SLICE_W-bit carry-select adder slice among NUM_REQ requesters.

---
 rtl/csa_ctrl_pkg.sv | 32 +++
 rtl/csa_add_slice.sv | 25 ++
 rtl/csa_multicycle_add_ctrl.sv | 142 ++++++++++++++
 tb/tb_csa_multicycle_add_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_ctrl_pkg.sv
// Shared types and helpers for the multicycle carry-select add controller.
package csa_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Upper bound on requesters supported by rr_pick; callers zero-extend into it.
  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_REQ_W = 4;

  function automatic int unsigned nchunk(input int unsigned data_w, input int unsigned slice_w);
    return data_w / slice_w;
  endfunction

  // One-hot grant to the first valid requester at or after ptr, scanning n entries.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input int unsigned        ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] grant;
    int unsigned        idx;
    grant = '0;
    for (int unsigned k = 0; k < n; k++) begin
      idx = (ptr + k) % n;
      if (grant == '0 && valid[idx[MAX_REQ_W-1:0]]) grant[idx[MAX_REQ_W-1:0]] = 1'b1;
    end
    return grant;
  endfunction

endpackage

// File: rtl/csa_add_slice.sv
// Combinational carry-select adder slice: both carry-in candidates are formed
// up front and the real carry-in only drives the final select.
module csa_add_slice #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         c_msb_o
);

  logic [W:0] sum_c0;
  logic [W:0] sum_c1;

  assign sum_c0 = {1'b0, a_i} + {1'b0, b_i};
  assign sum_c1 = {1'b0, a_i} + {1'b0, b_i} + (W+1)'(1);

  assign {cout_o, sum_o} = cin_i ? sum_c1 : sum_c0;

  // Carry into the top bit falls out of the top bit's sum equation.
  assign c_msb_o = a_i[W-1] ^ b_i[W-1] ^ sum_o[W-1];

endmodule

// File: rtl/csa_multicycle_add_ctrl.sv
// Round-robin sequencer sharing one SLICE_W-bit adder slice among NUM_REQ requesters,
// one chunk per cycle, LSB first. Define ADD_OVF_FLAG_EN to add the rsp_ovf output.
module csa_multicycle_add_ctrl
  import csa_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned SLICE_W = 6,
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  input  logic [NUM_REQ-1:0]          req_cin,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]           rsp_sum,
  output logic                        rsp_cout,
`ifdef ADD_OVF_FLAG_EN
  output logic                        rsp_ovf,
`endif
  output logic                        busy
);

  localparam int unsigned NCHUNK = nchunk(DATA_W, SLICE_W);
  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  if (DATA_W % SLICE_W != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of SLICE_W");
  end
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_nreq
    $error("NUM_REQ out of supported range");
  end

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, id_q, grant_id;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [DATA_W-1:0]  a_q, b_q, sum_q;
  logic [NUM_REQ-1:0] grant;
  logic               last_chunk;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout, slice_c_msb;

  always_comb begin
    grant    = NUM_REQ'(rr_pick(MAX_REQ'(req_valid), 32'(rr_ptr_q), NUM_REQ));
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_id = ID_W'(i);
    end
  end

  assign last_chunk = (cnt_q == LAST_CNT);

  csa_add_slice #(.W(SLICE_W)) u_slice (
    .a_i     (a_q[cnt_q*SLICE_W +: SLICE_W]),
    .b_i     (b_q[cnt_q*SLICE_W +: SLICE_W]),
    .cin_i   (carry_q),
    .sum_o   (slice_sum),
    .cout_o  (slice_cout),
    .c_msb_o (slice_c_msb)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: default assignment first so no path through the case leaves state_d
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|grant)     state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (rsp_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE && rst_n) ? grant : '0;
    rsp_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    rsp_id    = id_q;
    rsp_sum   = sum_q;
    rsp_cout  = carry_q;
  end

  // NOTE: result registers are cleared too, since their values drive rsp_* directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (|grant) begin
          a_q      <= req_a[grant_id*DATA_W +: DATA_W];
          b_q      <= req_b[grant_id*DATA_W +: DATA_W];
          carry_q  <= req_cin[grant_id];
          id_q     <= grant_id;
          cnt_q    <= '0;
          rr_ptr_q <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end
        RUN: begin
          sum_q[cnt_q*SLICE_W +: SLICE_W] <= slice_sum;
          carry_q <= slice_cout;
          cnt_q   <= last_chunk ? '0 : cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ADD_OVF_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                          ovf_q <= 1'b0;
    else if (state_q == RUN && last_chunk) ovf_q <= slice_c_msb ^ slice_cout;
  end

  assign rsp_ovf = ovf_q;
`else
  logic unused_c_msb;
  assign unused_c_msb = slice_c_msb;
`endif

endmodule

// File: tb/tb_csa_multicycle_add_ctrl.sv
// Self-checking bench: directed corner cases plus randomized traffic against a
// plain-arithmetic reference with a round-robin pointer model.
module tb_csa_multicycle_add_ctrl;

  localparam int DATA_W  = 24;
  localparam int SLICE_W = 6;
  localparam int NUM_REQ = 2;
  localparam int NCHUNK  = DATA_W / SLICE_W;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_cin;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_id;
  logic [DATA_W-1:0]         rsp_sum;
  logic                      rsp_cout;
  logic                      busy;
`ifdef ADD_OVF_FLAG_EN
  logic                      rsp_ovf;
`endif

  csa_multicycle_add_ctrl #(.DATA_W(DATA_W), .SLICE_W(SLICE_W), .NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
`ifdef ADD_OVF_FLAG_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] op_a [NUM_REQ];
  logic [DATA_W-1:0] op_b [NUM_REQ];
  logic              op_cin [NUM_REQ];
  int                ptr_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*DATA_W +: DATA_W] = op_a[i];
      req_b[i*DATA_W +: DATA_W] = op_b[i];
      req_cin[i]                = op_cin[i];
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_op();
    case ($urandom_range(5))
      0:       return 24'hFFFFFF;
      1:       return 24'h000000;
      2:       return 24'h7FFFFF;
      default: return DATA_W'($urandom);
    endcase
  endfunction

  task automatic randomize_req(input int r);
    op_a[r]   = rand_op();
    op_b[r]   = rand_op();
    op_cin[r] = 1'($urandom_range(1));
    drive_ops();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_sum",       32'(rsp_sum),   32'h0);
    check("rst_cout",      32'(rsp_cout),  32'h0);
    check("rst_id",        32'(rsp_id),    32'h0);
    req_valid = '0;
    rst_n     = 1'b1;
    ptr_m     = 0;
    tick();
  endtask

  // One full transaction from IDLE; mask stays asserted so others keep requesting.
  task automatic issue(input logic [1:0] mask, input int stall);
    int                exp_id;
    int                lat;
    logic [DATA_W:0]   exp_full;
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
    int                t;
    exp_id = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (ptr_m + k) % NUM_REQ;
      if (exp_id < 0 && mask[idx]) exp_id = idx;
    end
    req_valid = mask;
    #1;
    if (exp_id < 0) begin
      check("no_grant", 32'(req_ready), 32'h0);
      return;
    end
    t = 0;
    while (req_ready == '0 && t < 8) begin
      tick();
      t++;
    end
    if (req_ready == '0) begin
      check("grant_timeout", 32'(0), 32'(1));
      return;
    end
    check("grant", 32'(req_ready), 32'(1) << exp_id);
    ea       = op_a[exp_id];
    eb       = op_b[exp_id];
    exp_full = {1'b0, ea} + {1'b0, eb} + (DATA_W+1)'(op_cin[exp_id]);
    tick();
    randomize_req(exp_id);
    check("run_busy",  32'(busy),      32'h1);
    check("run_ready", 32'(req_ready), 32'h0);
    lat = 1;
    while (!rsp_valid && lat < 16) begin
      tick();
      if (!rsp_valid) check("run_ready", 32'(req_ready), 32'h0);
      if (rsp_valid) break;
      lat++;
    end
    if (!rsp_valid) begin
      check("rsp_timeout", 32'(0), 32'(1));
      do_reset();
      return;
    end
    check("latency", 32'(lat), 32'(NCHUNK));
    check("rsp_id",   32'(rsp_id),   32'(exp_id));
    check("rsp_sum",  32'(rsp_sum),  32'(exp_full[DATA_W-1:0]));
    check("rsp_cout", 32'(rsp_cout), 32'(exp_full[DATA_W]));
`ifdef ADD_OVF_FLAG_EN
    check("rsp_ovf", 32'(rsp_ovf),
          32'((ea[DATA_W-1] == eb[DATA_W-1]) && (exp_full[DATA_W-1] != ea[DATA_W-1])));
`endif
    for (int s = 0; s < stall; s++) begin
      tick();
      check("hold_valid", 32'(rsp_valid), 32'h1);
      check("hold_sum",   32'(rsp_sum),   32'(exp_full[DATA_W-1:0]));
      check("hold_id",    32'(rsp_id),    32'(exp_id));
      check("hold_ready", 32'(req_ready), 32'h0);
      check("hold_busy",  32'(busy),      32'h1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_valid", 32'(rsp_valid), 32'h0);
    check("post_busy",  32'(busy),      32'h0);
    ptr_m = (exp_id + 1) % NUM_REQ;
  endtask

  task automatic set_op(input int r, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic cin);
    op_a[r]   = a;
    op_b[r]   = b;
    op_cin[r] = cin;
    drive_ops();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, '0, '0, 1'b0);
    do_reset();

    set_op(0, 24'h00003F, 24'h000001, 1'b0);
    issue(2'b01, 0);
    req_valid = '0;
    set_op(1, 24'hFFFFFF, 24'h000001, 1'b0);
    issue(2'b10, 0);
    req_valid = '0;
    set_op(1, 24'hFFFFFF, 24'h000000, 1'b1);
    issue(2'b10, 3);
    req_valid = '0;
    set_op(0, 24'h7FFFFF, 24'h000001, 1'b0);
    issue(2'b01, 0);
    req_valid = '0;

    // Fairness: both requesters held valid, grants must alternate.
    do_reset();
    randomize_req(0);
    randomize_req(1);
    for (int i = 0; i < 4; i++) begin
      check("alt_ptr", 32'(ptr_m), 32'(i % 2));
      issue(2'b11, 0);
    end
    req_valid = '0;

    // Reset in the middle of chunk 2 discards the operation.
    set_op(1, 24'h123456, 24'h654321, 1'b1);
    req_valid = 2'b10;
    #1;
    check("mid_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_busy",  32'(busy),      32'h0);
    check("mid_valid", 32'(rsp_valid), 32'h0);
    check("mid_sum",   32'(rsp_sum),   32'h0);
    rst_n = 1'b1;
    ptr_m = 0;
    for (int i = 0; i < NCHUNK + 2; i++) begin
      tick();
      check("mid_no_rsp", 32'(rsp_valid), 32'h0);
    end
    randomize_req(0);
    randomize_req(1);
    req_valid = 2'b11;
    #1;
    check("mid_next_req0", 32'(req_ready), 32'h1);
    issue(2'b11, 0);

    for (int n = 0; n < 30; n++) begin
      logic [1:0] mask;
      mask = 2'($urandom_range(3));
      issue(mask, int'($urandom_range(3)));
      if (mask == '0) tick();
    end
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
